// File: rtl/video_timing_meter_if.sv
// Video timing meter bus: sync/colour inputs from the mixer, timing and pixel outputs.
interface video_timing_meter_if #(
  parameter int unsigned CNT_W = 12,
  parameter int unsigned COL_W = 2
);
  logic               hsync;
  logic               vsync;
  logic               hs_pol;
  logic               vs_pol;
  logic [COL_W-1:0]   red;
  logic [COL_W-1:0]   grn;
  logic [COL_W-1:0]   blu;
  logic [CNT_W-1:0]   hcount;
  logic [CNT_W-1:0]   vcount;
  logic [CNT_W-1:0]   hperiod;
  logic [CNT_W-1:0]   vperiod;
  logic               h_locked;
  logic               v_locked;
  logic               line_start;
  logic               frame_start;
  logic               pix_valid;
  logic [3*COL_W-1:0] pix_rgb;

  // Video source side: drives sync and colour, observes timing.
  modport master (
    output hsync, vsync, hs_pol, vs_pol, red, grn, blu,
    input  hcount, vcount, hperiod, vperiod, h_locked, v_locked,
           line_start, frame_start, pix_valid, pix_rgb
  );

  // Meter side.
  modport slave (
    input  hsync, vsync, hs_pol, vs_pol, red, grn, blu,
    output hcount, vcount, hperiod, vperiod, h_locked, v_locked,
           line_start, frame_start, pix_valid, pix_rgb
  );
endinterface

// File: rtl/video_timing_meter.sv
// Video timing meter: measures h/v sync periods, declares lock after LOCK_N
// equal periods, and emits pixel coordinates plus an aligned colour stream.
module video_timing_meter #(
  parameter int unsigned CNT_W  = 12,
  parameter int unsigned COL_W  = 2,
  parameter int unsigned LOCK_N = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  video_timing_meter_if.slave  vid
);

  localparam int unsigned MATCH_W = 4;
  localparam int unsigned RGB_W   = 3 * COL_W;
  localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [MATCH_W-1:0] MATCH_TOP = MATCH_W'(LOCK_N - 1);

  logic               hs1_q, hs1_d, hs2_q, hs2_d;
  logic               vs1_q, vs1_d, vs2_q, vs2_d;
  logic [CNT_W-1:0]   hcount_q, hcount_d;
  logic [CNT_W-1:0]   vcount_q, vcount_d;
  logic [CNT_W-1:0]   hlast_q, hlast_d;
  logic [CNT_W-1:0]   vlast_q, vlast_d;
  logic [CNT_W-1:0]   hperiod_q, hperiod_d;
  logic [CNT_W-1:0]   vperiod_q, vperiod_d;
  logic [MATCH_W-1:0] hmatch_q, hmatch_d;
  logic [MATCH_W-1:0] vmatch_q, vmatch_d;
  logic               h_locked_q, h_locked_d;
  logic               v_locked_q, v_locked_d;
  logic               line_start_q, line_start_d;
  logic               frame_start_q, frame_start_d;
  logic               vpend_q, vpend_d;
  logic [RGB_W-1:0]   rgb_dly_q, rgb_dly_d;
  logic [RGB_W-1:0]   pix_rgb_q, pix_rgb_d;

  logic               hedge_c, vedge_c;
  logic               hsat_c, vsat_c;
  logic [CNT_W-1:0]   hmeas_c, vmeas_c;

  // Active-edge detection on the two-stage sync history, polarity selectable.
  assign hedge_c = vid.hs_pol ? (hs1_q & ~hs2_q) : (~hs1_q & hs2_q);
  assign vedge_c = vid.vs_pol ? (vs1_q & ~vs2_q) : (~vs1_q & vs2_q);

  // Period candidates; a saturated counter yields an invalid (all-ones) measurement.
  assign hsat_c  = (hcount_q == CNT_MAX);
  assign vsat_c  = (vcount_q == CNT_MAX);
  assign hmeas_c = hsat_c ? CNT_MAX : hcount_q + CNT_W'(1);
  assign vmeas_c = vsat_c ? CNT_MAX : vcount_q + CNT_W'(1);

  // Next-state: counters, period matching, lock flags, pulses and colour delay.
  always_comb begin
    hs1_d         = vid.hsync;
    hs2_d         = hs1_q;
    vs1_d         = vid.vsync;
    vs2_d         = vs1_q;
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    hlast_d       = hlast_q;
    vlast_d       = vlast_q;
    hperiod_d     = hperiod_q;
    vperiod_d     = vperiod_q;
    hmatch_d      = hmatch_q;
    vmatch_d      = vmatch_q;
    h_locked_d    = h_locked_q;
    v_locked_d    = v_locked_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    vpend_d       = vpend_q;
    rgb_dly_d     = {vid.red, vid.grn, vid.blu};
    pix_rgb_d     = rgb_dly_q;

    if (vedge_c) begin
      vpend_d = 1'b1;
    end

    if (hedge_c) begin
      hcount_d     = '0;
      line_start_d = 1'b1;
      if (!hsat_c && (hmeas_c == hlast_q)) begin
        if (hmatch_q != MATCH_TOP) begin
          hmatch_d = hmatch_q + MATCH_W'(1);
        end
        if (hmatch_d == MATCH_TOP) begin
          h_locked_d = 1'b1;
          hperiod_d  = hmeas_c;
        end
      end else begin
        hmatch_d   = '0;
        h_locked_d = 1'b0;
        hperiod_d  = '0;
      end
      hlast_d = hmeas_c;

      if (vpend_q || vedge_c) begin
        vcount_d      = '0;
        frame_start_d = 1'b1;
        vpend_d       = 1'b0;
        if (!vsat_c && (vmeas_c == vlast_q)) begin
          if (vmatch_q != MATCH_TOP) begin
            vmatch_d = vmatch_q + MATCH_W'(1);
          end
          if (vmatch_d == MATCH_TOP) begin
            v_locked_d = 1'b1;
            vperiod_d  = vmeas_c;
          end
        end else begin
          vmatch_d   = '0;
          v_locked_d = 1'b0;
          vperiod_d  = '0;
        end
        vlast_d = vmeas_c;
      end else begin
        if (!vsat_c) begin
          vcount_d = vcount_q + CNT_W'(1);
        end
        if (vcount_d == CNT_MAX) begin
          vmatch_d   = '0;
          v_locked_d = 1'b0;
          vperiod_d  = '0;
        end
      end
    end else begin
      if (!hsat_c) begin
        hcount_d = hcount_q + CNT_W'(1);
      end
      // Line timeout: sync has gone away long enough to saturate the counter.
      if (hcount_d == CNT_MAX) begin
        hmatch_d   = '0;
        h_locked_d = 1'b0;
        hperiod_d  = '0;
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs1_q         <= 1'b0;
      hs2_q         <= 1'b0;
      vs1_q         <= 1'b0;
      vs2_q         <= 1'b0;
      hcount_q      <= '0;
      vcount_q      <= '0;
      hlast_q       <= '0;
      vlast_q       <= '0;
      hperiod_q     <= '0;
      vperiod_q     <= '0;
      hmatch_q      <= '0;
      vmatch_q      <= '0;
      h_locked_q    <= 1'b0;
      v_locked_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      vpend_q       <= 1'b0;
      rgb_dly_q     <= '0;
      pix_rgb_q     <= '0;
    end else begin
      hs1_q         <= hs1_d;
      hs2_q         <= hs2_d;
      vs1_q         <= vs1_d;
      vs2_q         <= vs2_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hlast_q       <= hlast_d;
      vlast_q       <= vlast_d;
      hperiod_q     <= hperiod_d;
      vperiod_q     <= vperiod_d;
      hmatch_q      <= hmatch_d;
      vmatch_q      <= vmatch_d;
      h_locked_q    <= h_locked_d;
      v_locked_q    <= v_locked_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      vpend_q       <= vpend_d;
      rgb_dly_q     <= rgb_dly_d;
      pix_rgb_q     <= pix_rgb_d;
    end
  end

  // Output mapping; pix_valid is the only combinational output.
  assign vid.hcount      = hcount_q;
  assign vid.vcount      = vcount_q;
  assign vid.hperiod     = hperiod_q;
  assign vid.vperiod     = vperiod_q;
  assign vid.h_locked    = h_locked_q;
  assign vid.v_locked    = v_locked_q;
  assign vid.line_start  = line_start_q;
  assign vid.frame_start = frame_start_q;
  assign vid.pix_rgb     = pix_rgb_q;
  assign vid.pix_valid   = h_locked_q & v_locked_q;

endmodule

// File: doc/video_timing_meter.md
Name: video_timing_meter

Overview:
- Synthesisable, parametrised successor to the simulation-only raster visualiser.
- Recovers horizontal and vertical sync periods from the video output, and requires several matching periods before declaring lock.
- Detects sync loss and generates pixel coordinates and pixel-valid strobes for a downstream frame-capture or overlay block.
- Sits on the video DAC path after the video mixer. Sync inputs are synchronous to clk.

Parameters:
- CNT_W, 12: width of the h/v counters and period registers; all-ones is the saturation/timeout value.
- COL_W, 2: bits per colour channel.
- LOCK_N, 2: number of consecutive identical period measurements needed for lock (2..15).

Ports:
- clk  in  1  system clock (pixel-rate or multiple).
- rst_n  in  1  asynchronous active-low reset.
- hsync  in  1  horizontal sync, synchronous to clk.
- vsync  in  1  vertical sync, synchronous to clk.
- hs_pol  in  1  1: hsync rising edge is active; 0: falling edge.
- vs_pol  in  1  same for vsync.
- red/grn/blu  in  COL_W each  pixel colour.
- hcount  out  CNT_W  clocks since last active hsync edge.
- vcount  out  CNT_W  lines since frame start.
- hperiod  out  CNT_W  locked line length in clocks; 0 when unlocked.
- vperiod  out  CNT_W  locked frame length in lines; 0 when unlocked.
- h_locked, v_locked  out  1  lock flags.
- line_start  out  1  one-clock pulse on the active hsync edge.
- frame_start  out  1  one-clock pulse on the line that restarts vcount.
- pix_valid  out  1  h_locked & v_locked.
- pix_rgb  out  3*COL_W  {red,grn,blu}, delayed to align with hcount/vcount.

Behaviour:
- Reset (async, rst_n=0):
  - all counters, periods, match counters, flags, pulses and pix_rgb = 0.
  - sync history registers = 0; vpend = 0.
- Edge detect:
  - s1<=sync, s2<=s1.
  - Active edge = (s1 & ~s2) when pol=1, (~s1 & s2) when pol=0.
  - Latency from a sync pin change to line_start is 2 clocks. rgb is delayed 2 clocks to match.
  - A polarity change mid-run is allowed. It can create a spurious edge, which is handled as a normal measurement mismatch.
- Horizontal counter:
  - On hedge: hcount<=0, line_start<=1.
  - Otherwise: hcount<=hcount+1, saturating at all-ones.
- Horizontal measurement, on hedge:
  - meas = hcount+1. It is invalid if hcount is saturated.
  - If valid and meas==hlast: hmatch++ (saturating at LOCK_N-1). Otherwise hmatch<=0.
  - hlast<=meas.
  - When hmatch reaches LOCK_N-1 (LOCK_N equal periods): h_locked<=1, hperiod<=meas.
  - A mismatch while locked clears h_locked and hperiod the same cycle. The first hedge after reset only loads hlast.
- Horizontal timeout: hcount reaching all-ones clears h_locked, hperiod and hmatch.
- Vertical:
  - vedge sets vpend.
  - On the next hedge, or the same-cycle hedge if both coincide, with vpend or vedge set:
    - vmeas=vcount+1, vcount<=0, frame_start<=1, vpend<=0.
    - Lock logic is identical to horizontal, using vlast/vmatch/v_locked/vperiod.
  - Other hedges: vcount<=vcount+1, saturating.
  - vcount saturation clears v_locked, vperiod and vmatch.
  - vmeas is invalid if vcount is saturated.
- Multiple vedges before one hedge are treated as one.
- frame_start implies line_start in the same cycle.
- pix_valid is combinational from the lock flags.
- All arithmetic is unsigned CNT_W with no wrap: counters saturate, never roll over.

Test Plan:
1. hs_pol=1, rising hsync every 448 clocks (32-clock pulse), LOCK_N=2 -> line_start 2 clocks after each rising pin edge. h_locked=1, hperiod=448 at the 3rd edge (2nd measurement). hcount runs 0..447.
2. vsync rising every 320 lines with the same hsync -> frame_start on the hedge after vedge, vcount 0..319. v_locked=1 and vperiod=320 after the second full frame. pix_valid=1.
3. While locked, one line shortened to 447 -> h_locked and hperiod drop to 0 on that edge. Relock with hperiod=448 after two consecutive 448 measurements.
4. Stop hsync with CNT_W=12 -> hcount sticks at 4095, h_locked=0 after 4095 clocks. Restarting hsync relocks with no rollover artefacts.
5. vsync edge in the same cycle as hsync edge -> frame_start and vcount=0 that cycle. A vsync pulse spanning two vedges before an hedge -> a single frame_start.
6. Assert rst_n=0 mid-frame -> all outputs 0 immediately (asynchronous). After release, lock needs LOCK_N fresh matching periods. Repeat 1 with hs_pol=0 and an inverted hsync -> identical results.
